// File: rtl/rename_register_file.sv
// Dual-issue architectural register file with rename tags (value/busy/tag per register).
// Optional same-cycle commit forwarding on reads is enabled by defining RF_COMMIT_BYPASS_EN.
module rename_register_file #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREG)-1:0]  dec0_rs1_in,
  input  logic [$clog2(NREG)-1:0]  dec0_rs2_in,
  input  logic [$clog2(NREG)-1:0]  dec0_rd_in,
  input  logic                     dec0_occupy_rd_in,
  input  logic [TAG_W-1:0]         dec0_tag_in,
  output logic [XLEN-1:0]          dec0_Vj_out,
  output logic [XLEN-1:0]          dec0_Vk_out,
  output logic [TAG_W-1:0]         dec0_Qj_out,
  output logic [TAG_W-1:0]         dec0_Qk_out,
  input  logic [$clog2(NREG)-1:0]  dec1_rs1_in,
  input  logic [$clog2(NREG)-1:0]  dec1_rs2_in,
  input  logic [$clog2(NREG)-1:0]  dec1_rd_in,
  input  logic                     dec1_occupy_rd_in,
  input  logic [TAG_W-1:0]         dec1_tag_in,
  output logic [XLEN-1:0]          dec1_Vj_out,
  output logic [XLEN-1:0]          dec1_Vk_out,
  output logic [TAG_W-1:0]         dec1_Qj_out,
  output logic [TAG_W-1:0]         dec1_Qk_out,
  input  logic                     rob_rollback_in,
  input  logic                     rob_commit_in,
  input  logic                     rob_commit_rf_in,
  input  logic [TAG_W-1:0]         rob_commit_tag_in,
  input  logic [$clog2(NREG)-1:0]  rob_commit_target_in,
  input  logic [XLEN-1:0]          rob_commit_data_in
);

  localparam int unsigned IDX_W = $clog2(NREG);
  localparam int unsigned OP_W  = XLEN + TAG_W;

  logic [XLEN-1:0]  value [NREG];
  logic [TAG_W-1:0] tag   [NREG];
  logic [NREG-1:0]  busy;

  logic commit_wr;
  assign commit_wr = rob_commit_in && rob_commit_rf_in;

  // Resolve one operand to {V, Q}; grp_dep enables the channel-0 -> channel-1 rename check.
  function automatic logic [OP_W-1:0] read_op(input logic [IDX_W-1:0] rs, input logic grp_dep);
    logic [OP_W-1:0] r;
    if (rs == '0) begin
      r = '0;
    end else if (grp_dep && dec0_occupy_rd_in && (dec0_rd_in == rs)) begin
      r = {XLEN'(0), dec0_tag_in};
`ifdef RF_COMMIT_BYPASS_EN
    end else if (commit_wr && (rob_commit_target_in == rs) && busy[rs] &&
                 (tag[rs] == rob_commit_tag_in)) begin
      r = {rob_commit_data_in, TAG_W'(0)};
`endif
    end else if (busy[rs]) begin
      r = {XLEN'(0), tag[rs]};
    end else begin
      r = {value[rs], TAG_W'(0)};
    end
    return r;
  endfunction

  always_comb begin
    {dec0_Vj_out, dec0_Qj_out} = read_op(dec0_rs1_in, 1'b0);
    {dec0_Vk_out, dec0_Qk_out} = read_op(dec0_rs2_in, 1'b0);
    {dec1_Vj_out, dec1_Qj_out} = read_op(dec1_rs1_in, 1'b1);
    {dec1_Vk_out, dec1_Qk_out} = read_op(dec1_rs2_in, 1'b1);
  end

  // Commit, then rollback, then ch0 occupy, then ch1 occupy; later assignments win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < NREG; i++) begin
        value[i] <= '0;
        tag[i]   <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (commit_wr && (rob_commit_target_in == IDX_W'(i))) begin
          value[i] <= rob_commit_data_in;
          if (busy[i] && (tag[i] == rob_commit_tag_in)) begin
            busy[i] <= 1'b0;
            tag[i]  <= '0;
          end
        end
        if (rob_rollback_in) begin
          busy[i] <= 1'b0;
          tag[i]  <= '0;
        end else begin
          if (dec0_occupy_rd_in && (dec0_rd_in == IDX_W'(i))) begin
            busy[i] <= 1'b1;
            tag[i]  <= dec0_tag_in;
          end
          if (dec1_occupy_rd_in && (dec1_rd_in == IDX_W'(i))) begin
            busy[i] <= 1'b1;
            tag[i]  <= dec1_tag_in;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_register_file.sv
// Self-checking bench for rename_register_file: directed scenarios plus randomized traffic
// against an array-based reference model (honours RF_COMMIT_BYPASS_EN when defined).
module tb_rename_register_file;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned TAG_W = 4;

  logic clk, rst;
  logic [4:0] dec0_rs1_in, dec0_rs2_in, dec0_rd_in, dec1_rs1_in, dec1_rs2_in, dec1_rd_in;
  logic dec0_occupy_rd_in, dec1_occupy_rd_in;
  logic [3:0] dec0_tag_in, dec1_tag_in;
  logic [31:0] dec0_Vj_out, dec0_Vk_out, dec1_Vj_out, dec1_Vk_out;
  logic [3:0] dec0_Qj_out, dec0_Qk_out, dec1_Qj_out, dec1_Qk_out;
  logic rob_rollback_in, rob_commit_in, rob_commit_rf_in;
  logic [3:0] rob_commit_tag_in;
  logic [4:0] rob_commit_target_in;
  logic [31:0] rob_commit_data_in;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [31:0] m_val  [NREG];
  logic        m_busy [NREG];
  logic [3:0]  m_tag  [NREG];

  rename_register_file #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .dec0_rs1_in(dec0_rs1_in), .dec0_rs2_in(dec0_rs2_in), .dec0_rd_in(dec0_rd_in),
    .dec0_occupy_rd_in(dec0_occupy_rd_in), .dec0_tag_in(dec0_tag_in),
    .dec0_Vj_out(dec0_Vj_out), .dec0_Vk_out(dec0_Vk_out),
    .dec0_Qj_out(dec0_Qj_out), .dec0_Qk_out(dec0_Qk_out),
    .dec1_rs1_in(dec1_rs1_in), .dec1_rs2_in(dec1_rs2_in), .dec1_rd_in(dec1_rd_in),
    .dec1_occupy_rd_in(dec1_occupy_rd_in), .dec1_tag_in(dec1_tag_in),
    .dec1_Vj_out(dec1_Vj_out), .dec1_Vk_out(dec1_Vk_out),
    .dec1_Qj_out(dec1_Qj_out), .dec1_Qk_out(dec1_Qk_out),
    .rob_rollback_in(rob_rollback_in), .rob_commit_in(rob_commit_in),
    .rob_commit_rf_in(rob_commit_rf_in), .rob_commit_tag_in(rob_commit_tag_in),
    .rob_commit_target_in(rob_commit_target_in), .rob_commit_data_in(rob_commit_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
  endtask

  // Expected {V, Q} for one operand, straight from the read priority rules.
  function automatic logic [35:0] exp_read(input logic [4:0] rs, input bit ch1);
    if (rs == 5'd0) return '0;
    if (ch1 && dec0_occupy_rd_in && dec0_rd_in == rs) return {32'd0, dec0_tag_in};
`ifdef RF_COMMIT_BYPASS_EN
    if (rob_commit_in && rob_commit_rf_in && rob_commit_target_in == rs && m_busy[rs] &&
        m_tag[rs] == rob_commit_tag_in) return {rob_commit_data_in, 4'd0};
`endif
    if (m_busy[rs]) return {32'd0, m_tag[rs]};
    return {m_val[rs], 4'd0};
  endfunction

  task automatic idle();
    {dec0_rs1_in, dec0_rs2_in, dec0_rd_in, dec1_rs1_in, dec1_rs2_in, dec1_rd_in} = '0;
    {dec0_occupy_rd_in, dec1_occupy_rd_in, dec0_tag_in, dec1_tag_in} = '0;
    {rob_rollback_in, rob_commit_in, rob_commit_rf_in, rob_commit_tag_in} = '0;
    rob_commit_target_in = '0;
    rob_commit_data_in = '0;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (rob_commit_in && rob_commit_rf_in && rob_commit_target_in != 0) begin
      m_val[rob_commit_target_in] = rob_commit_data_in;
      if (m_busy[rob_commit_target_in] && m_tag[rob_commit_target_in] == rob_commit_tag_in) begin
        m_busy[rob_commit_target_in] = 1'b0;
        m_tag[rob_commit_target_in] = '0;
      end
    end
    if (rob_rollback_in) begin
      for (int i = 0; i < NREG; i++) begin m_busy[i] = 1'b0; m_tag[i] = '0; end
    end else begin
      if (dec0_occupy_rd_in && dec0_rd_in != 0) begin
        m_busy[dec0_rd_in] = 1'b1; m_tag[dec0_rd_in] = dec0_tag_in;
      end
      if (dec1_occupy_rd_in && dec1_rd_in != 0) begin
        m_busy[dec1_rd_in] = 1'b1; m_tag[dec1_rd_in] = dec1_tag_in;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    model_clear();
    dec0_rs1_in = 5'd5; dec0_rs2_in = 5'd5; dec1_rs1_in = 5'd5; dec1_rs2_in = 5'd5;
    #1;
    checks++;
    if ({dec0_Vj_out, dec0_Qj_out, dec0_Vk_out, dec0_Qk_out} !== '0) begin
      fails++; $display("FAIL reset_ch0: got V=%h/%h Q=%0d/%0d, want 0", dec0_Vj_out, dec0_Vk_out, dec0_Qj_out, dec0_Qk_out);
    end
    checks++;
    if ({dec1_Vj_out, dec1_Qj_out, dec1_Vk_out, dec1_Qk_out} !== '0) begin
      fails++; $display("FAIL reset_ch1: got V=%h/%h Q=%0d/%0d, want 0", dec1_Vj_out, dec1_Vk_out, dec1_Qj_out, dec1_Qk_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_occupy_commit();
    idle(); dec0_occupy_rd_in = 1'b1; dec0_rd_in = 5'd3; dec0_tag_in = 4'd2;
    tick();
    idle(); dec0_rs1_in = 5'd3; #1;
    checks++;
    if (dec0_Qj_out !== 4'd2 || dec0_Vj_out !== 32'd0) begin
      fails++; $display("FAIL occupy_x3: got V=%h Q=%0d, want V=0 Q=2", dec0_Vj_out, dec0_Qj_out);
    end
    rob_commit_in = 1'b1; rob_commit_rf_in = 1'b1; rob_commit_tag_in = 4'd2;
    rob_commit_target_in = 5'd3; rob_commit_data_in = 32'hDEADBEEF;
    tick();
    idle(); dec0_rs1_in = 5'd3; #1;
    checks++;
    if (dec0_Vj_out !== 32'hDEADBEEF || dec0_Qj_out !== 4'd0) begin
      fails++; $display("FAIL commit_x3: got V=%h Q=%0d, want V=deadbeef Q=0", dec0_Vj_out, dec0_Qj_out);
    end
  endtask

  task automatic test_same_group();
    idle(); dec0_occupy_rd_in = 1'b1; dec0_rd_in = 5'd7; dec0_tag_in = 4'd4; dec1_rs2_in = 5'd7; #1;
    checks++;
    if (dec1_Qk_out !== 4'd4 || dec1_Vk_out !== 32'd0) begin
      fails++; $display("FAIL group_dep: got V=%h Q=%0d, want V=0 Q=4", dec1_Vk_out, dec1_Qk_out);
    end
    tick();
    idle();
    dec0_occupy_rd_in = 1'b1; dec0_rd_in = 5'd7; dec0_tag_in = 4'd4;
    dec1_occupy_rd_in = 1'b1; dec1_rd_in = 5'd7; dec1_tag_in = 4'd5;
    tick();
    idle(); dec0_rs1_in = 5'd7; dec1_rs1_in = 5'd7; #1;
    checks++;
    if (dec0_Qj_out !== 4'd5 || dec1_Qj_out !== 4'd5) begin
      fails++; $display("FAIL dual_occupy: got Q=%0d/%0d, want 5/5", dec0_Qj_out, dec1_Qj_out);
    end
  endtask

  task automatic test_tag_mismatch();
    idle(); dec0_occupy_rd_in = 1'b1; dec0_rd_in = 5'd9; dec0_tag_in = 4'd6;
    tick();
    idle(); rob_commit_in = 1'b1; rob_commit_rf_in = 1'b1; rob_commit_tag_in = 4'd3;
    rob_commit_target_in = 5'd9; rob_commit_data_in = 32'h11;
    tick();
    idle(); dec0_rs1_in = 5'd9; #1;
    checks++;
    if (dec0_Qj_out !== 4'd6 || dec0_Vj_out !== 32'd0) begin
      fails++; $display("FAIL mismatch_busy: got V=%h Q=%0d, want V=0 Q=6", dec0_Vj_out, dec0_Qj_out);
    end
    rob_rollback_in = 1'b1;
    tick();
    idle(); dec0_rs1_in = 5'd9; #1;
    checks++;
    if (dec0_Vj_out !== 32'h11 || dec0_Qj_out !== 4'd0) begin
      fails++; $display("FAIL mismatch_value: got V=%h Q=%0d, want V=11 Q=0", dec0_Vj_out, dec0_Qj_out);
    end
  endtask

  task automatic test_commit_bypass();
    idle(); dec0_occupy_rd_in = 1'b1; dec0_rd_in = 5'd9; dec0_tag_in = 4'd6;
    tick();
    idle(); rob_commit_in = 1'b1; rob_commit_rf_in = 1'b1; rob_commit_tag_in = 4'd6;
    rob_commit_target_in = 5'd9; rob_commit_data_in = 32'h22; dec0_rs1_in = 5'd9; #1;
    checks++;
`ifdef RF_COMMIT_BYPASS_EN
    if (dec0_Vj_out !== 32'h22 || dec0_Qj_out !== 4'd0) begin
      fails++; $display("FAIL bypass_cycle: got V=%h Q=%0d, want V=22 Q=0", dec0_Vj_out, dec0_Qj_out);
    end
`else
    if (dec0_Vj_out !== 32'd0 || dec0_Qj_out !== 4'd6) begin
      fails++; $display("FAIL bypass_cycle: got V=%h Q=%0d, want V=0 Q=6", dec0_Vj_out, dec0_Qj_out);
    end
`endif
    tick();
    idle(); dec0_rs1_in = 5'd9; #1;
    checks++;
    if (dec0_Vj_out !== 32'h22 || dec0_Qj_out !== 4'd0) begin
      fails++; $display("FAIL bypass_after: got V=%h Q=%0d, want V=22 Q=0", dec0_Vj_out, dec0_Qj_out);
    end
  endtask

  task automatic test_rollback();
    idle(); rob_commit_in = 1'b1; rob_commit_rf_in = 1'b1; rob_commit_target_in = 5'd4; rob_commit_data_in = 32'h44;
    tick();
    idle(); rob_commit_in = 1'b1; rob_commit_rf_in = 1'b1; rob_commit_target_in = 5'd8; rob_commit_data_in = 32'h88;
    tick();
    idle(); dec0_occupy_rd_in = 1'b1; dec0_rd_in = 5'd4; dec0_tag_in = 4'd7;
    tick();
    idle(); rob_rollback_in = 1'b1; dec0_occupy_rd_in = 1'b1; dec0_rd_in = 5'd8; dec0_tag_in = 4'd8;
    tick();
    idle(); dec0_rs1_in = 5'd4; dec0_rs2_in = 5'd8; #1;
    checks++;
    if (dec0_Vj_out !== 32'h44 || dec0_Qj_out !== 4'd0) begin
      fails++; $display("FAIL rollback_x4: got V=%h Q=%0d, want V=44 Q=0", dec0_Vj_out, dec0_Qj_out);
    end
    checks++;
    if (dec0_Vk_out !== 32'h88 || dec0_Qk_out !== 4'd0) begin
      fails++; $display("FAIL rollback_x8: got V=%h Q=%0d, want V=88 Q=0", dec0_Vk_out, dec0_Qk_out);
    end
  endtask

  task automatic test_x0();
    idle(); dec0_occupy_rd_in = 1'b1; dec0_rd_in = 5'd0; dec0_tag_in = 4'd3;
    dec1_occupy_rd_in = 1'b1; dec1_rd_in = 5'd0; dec1_tag_in = 4'd9;
    rob_commit_in = 1'b1; rob_commit_rf_in = 1'b1; rob_commit_target_in = 5'd0; rob_commit_data_in = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (dec1_Vj_out !== 32'd0 || dec1_Qj_out !== 4'd0) begin
      fails++; $display("FAIL x0_group: got V=%h Q=%0d, want 0", dec1_Vj_out, dec1_Qj_out);
    end
    tick();
    idle(); #1;
    checks++;
    if ({dec0_Vj_out, dec0_Qj_out, dec1_Vk_out, dec1_Qk_out} !== '0) begin
      fails++; $display("FAIL x0_after: got V=%h/%h Q=%0d/%0d, want 0", dec0_Vj_out, dec1_Vk_out, dec0_Qj_out, dec1_Qk_out);
    end
  endtask

  task automatic test_random();
    logic [4:0]  rs [4];
    logic [31:0] av [4];
    logic [3:0]  aq [4];
    logic [35:0] e;
    for (int c = 0; c < 300; c++) begin
      idle();
      dec0_rs1_in = 5'($urandom_range(0, 7)); dec0_rs2_in = 5'($urandom_range(0, 7));
      dec1_rs1_in = 5'($urandom_range(0, 7)); dec1_rs2_in = 5'($urandom_range(0, 7));
      dec0_rd_in = 5'($urandom_range(0, 7)); dec1_rd_in = 5'($urandom_range(0, 7));
      dec0_occupy_rd_in = 1'($urandom_range(0, 1)); dec1_occupy_rd_in = 1'($urandom_range(0, 1));
      dec0_tag_in = 4'($urandom_range(1, 15)); dec1_tag_in = 4'($urandom_range(1, 15));
      rob_commit_in = 1'($urandom_range(0, 1)); rob_commit_rf_in = 1'($urandom_range(0, 3) != 0);
      rob_commit_target_in = 5'($urandom_range(0, 7));
      rob_commit_tag_in = ($urandom_range(0, 1) != 0) ? m_tag[rob_commit_target_in] : 4'($urandom_range(1, 15));
      rob_commit_data_in = $urandom;
      rob_rollback_in = 1'($urandom_range(0, 15) == 0);
      #1;
      rs[0] = dec0_rs1_in; rs[1] = dec0_rs2_in; rs[2] = dec1_rs1_in; rs[3] = dec1_rs2_in;
      av[0] = dec0_Vj_out; av[1] = dec0_Vk_out; av[2] = dec1_Vj_out; av[3] = dec1_Vk_out;
      aq[0] = dec0_Qj_out; aq[1] = dec0_Qk_out; aq[2] = dec1_Qj_out; aq[3] = dec1_Qk_out;
      for (int k = 0; k < 4; k++) begin
        e = exp_read(rs[k], k >= 2);
        checks++;
        if ({av[k], aq[k]} !== e) begin
          fails++;
          $display("FAIL random_read cyc=%0d op=%0d rs=%0d: got V=%h Q=%0d, want V=%h Q=%0d",
                   c, k, rs[k], av[k], aq[k], e[35:4], e[3:0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    idle(); dec0_occupy_rd_in = 1'b1; dec0_rd_in = 5'd5; dec0_tag_in = 4'd9;
    tick();
    idle(); dec0_rs1_in = 5'd5; dec0_rs2_in = 5'd4; dec1_rs1_in = 5'd9;
    #2 rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if ({dec0_Vj_out, dec0_Qj_out, dec0_Vk_out, dec0_Qk_out, dec1_Vj_out, dec1_Qj_out} !== '0) begin
      fails++; $display("FAIL async_reset: got V=%h/%h/%h Q=%0d/%0d/%0d, want 0",
                        dec0_Vj_out, dec0_Vk_out, dec1_Vj_out, dec0_Qj_out, dec0_Qk_out, dec1_Qj_out);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    dec0_rs1_in = 5'd5; #1;
    checks++;
    if (dec0_Vj_out !== 32'd0 || dec0_Qj_out !== 4'd0) begin
      fails++; $display("FAIL post_reset: got V=%h Q=%0d, want 0", dec0_Vj_out, dec0_Qj_out);
    end
  endtask

  initial begin
    test_reset();
    test_occupy_commit();
    test_same_group();
    test_tag_mismatch();
    test_commit_bypass();
    test_rollback();
    test_x0();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rename_register_file.md
# rename_register_file

Dual-issue, parametrised architectural register file with rename tags for the Tomasulo core. It sits between the Decoder and the ReorderBuffer, and holds per register a committed value, a busy flag and the ROB tag of the youngest in-flight producer. It serves Vj/Vk/Qj/Qk for two decode channels per cycle. It resolves same-group dependencies between channel 0 and channel 1, and can optionally forward a same-cycle commit.

## Interface
Parameters:
- XLEN, 32: data word width.
- NREG, 32: number of architectural registers; register 0 is hard-wired zero.
- TAG_W, 4: ROB tag width; tag 0 is the null tag, and valid tags are 1..2^TAG_W-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- decN_rs1_in, decN_rs2_in  in  $clog2(NREG)  source indices, channel N (N = 0, 1).
- decN_rd_in  in  $clog2(NREG)  destination index, channel N.
- decN_occupy_rd_in  in  1  channel N renames rd this cycle.
- decN_tag_in  in  TAG_W  ROB tag allocated to channel N.
- decN_Vj_out, decN_Vk_out  out  XLEN  operand values; 0 when a tag is returned.
- decN_Qj_out, decN_Qk_out  out  TAG_W  producer tags; 0 when the value is ready.
- rob_rollback_in  in  1  flush all renames.
- rob_commit_in  in  1  a ROB entry commits this cycle.
- rob_commit_rf_in  in  1  the committing entry writes a register.
- rob_commit_tag_in  in  TAG_W  tag of the committing entry.
- rob_commit_target_in  in  $clog2(NREG)  destination register.
- rob_commit_data_in  in  XLEN  result value.

## Operation
State per register: value[XLEN], busy, tag[TAG_W].

Reads are combinational, resolved per operand in this priority order:
1. Index 0 -> V=0, Q=0.
2. Channel 1 only: if dec0_occupy_rd_in and dec0_rd_in == rs and rs != 0 -> V=0, Q=dec0_tag_in.
3. Bypass (macro only): if rob_commit_in, rob_commit_rf_in, target == rs, busy[rs] and tag[rs] == rob_commit_tag_in -> V=rob_commit_data_in, Q=0.
4. busy[rs] -> V=0, Q=tag[rs].
5. Otherwise -> V=value[rs], Q=0.

Update on clock edge, in this order with later items winning:
1. Commit: when rob_commit_in, rob_commit_rf_in and target != 0 -> value[target] <= data. In addition, if busy[target] and tag[target] == commit tag, clear busy and tag. A commit with a mismatched tag writes the value only.
2. Rollback: clear every busy and tag. Decode occupy requests are ignored that cycle. The commit value write still happens.
3. Channel 0 occupy, rd != 0 -> busy=1, tag=dec0_tag_in.
4. Channel 1 occupy, rd != 0 -> busy=1, tag=dec1_tag_in. This overrides channel 0 on the same rd.

Boundary behaviour:
- A same-cycle commit and occupy on the same register leaves the register busy with the new tag; the value is still written.
- Register 0 is never busy and never written.

## Timing
- Reset (async): all values 0, busy 0, tags 0. Outputs therefore read V=0, Q=0 for every index one delta after rst asserts.
- Read latency is 0 cycles and combinational from current state plus the same-cycle inputs listed above.
- Occupy and commit effects are visible on reads in the cycle after the edge.
- Deasserting rst mid-stream resumes from the all-clear state; no pending commit is retained.

## Configuration
- RF_COMMIT_BYPASS_EN defined: read step 3 is active, so a decode read in the commit cycle returns the committed data with a null tag.
- Not defined: step 3 is omitted, and the read returns Q=tag in that cycle. The consumer then relies on the CDB broadcast; state updates are identical.

## Test plan
- Reset, then read x5 on both channels -> V=0, Q=0.
- Ch0 occupies x3 with tag 2; next cycle ch0 reads rs1=x3 -> Qj=2, Vj=0. Commit tag 2, target x3, data 0xDEADBEEF; next cycle -> Vj=0xDEADBEEF, Qj=0.
- Same cycle: ch0 occupies x7 with tag 4, ch1 reads rs2=x7 -> dec1_Qk=4. In a separate cycle, both channels occupy x7 with tags 4 and 5 -> next cycle Q=5.
- x9 busy with tag 6; commit tag 3, target x9, data 0x11 -> value updated, x9 still busy with Q=6.
- x9 busy with tag 6; commit tag 6 with data 0x22 while ch0 reads x9 -> with macro V=0x22, Q=0; without macro Q=6. In both cases, the next cycle reads V=0x22.
- x4 busy; rollback together with ch0 occupying x8 -> next cycle x4 and x8 both read Q=0 with their old values. Writing x0 via occupy and commit -> x0 stays 0.
